// File: rtl/regfile_pkg.sv
// Shared register-file types and constants (register file, decode, write-back).
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 64;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t XZR_ADDR = 5'd31;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; a tie goes to the requester that did not win last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_q = 1 means requester 1 won the most recent grant
    logic last_q;
    logic last_d;

    // Grant: a lone requester wins, a tie goes against the last winner
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the winner only when something was granted
    always_comb begin
        last_d = last_q;
        if (gnt != 2'b00) begin
            last_d = gnt[1];
        end
    end

    // Reset pretends requester 1 won last so requester 0 takes the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter onto the register-file write port plus pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = REG_DATA_W,
    parameter int unsigned ADDR_W  = REG_ADDR_W,
    parameter int unsigned ZR_ADDR = 32'(XZR_ADDR)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req0_valid,
    input  logic [ADDR_W-1:0]        req0_addr,
    input  logic [DATA_W-1:0]        req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDR_W-1:0]        req1_addr,
    input  logic [DATA_W-1:0]        req1_data,
    output logic                     req1_ready,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     we3,
    output logic [ADDR_W-1:0]        wa3,
    output logic [DATA_W-1:0]        wd3,
    output logic [(1 << ADDR_W)-1:0] pending
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [1:0]        gnt;
    logic              xfer;
    logic              wr_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] wa3_q, wa3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic [NREG-1:0]   pending_q, pending_d;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({req1_valid, req0_valid}),
        .gnt     (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Winning request mux and zero-register filter
    always_comb begin
        xfer     = gnt[0] | gnt[1];
        sel_addr = gnt[1] ? req1_addr : req0_addr;
        sel_data = gnt[1] ? req1_data : req0_data;
        wr_en    = xfer && (sel_addr != ADDR_W'(ZR_ADDR));
    end

    // Next write-port values; address/data hold when nothing is written
    always_comb begin
        we3_d = wr_en;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (wr_en) begin
            wa3_d = sel_addr;
            wd3_d = sel_data;
        end
    end

    // Scoreboard: clear on issued write, then set on reservation so a newer reservation wins
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[sel_addr] = 1'b0;
        end
        if (rsv_valid) begin
            pending_d[rsv_addr] = 1'b1;
        end
        pending_d[ZR_ADDR] = 1'b0;
    end

    // Output register stage and scoreboard state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we3_q     <= 1'b0;
            wa3_q     <= '0;
            wd3_q     <= '0;
            pending_q <= '0;
        end else begin
            we3_q     <= we3_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
            pending_q <= pending_d;
        end
    end

    assign we3     = we3_q;
    assign wa3     = wa3_q;
    assign wd3     = wd3_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, corner sequences, random vs model.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req1_valid, rsv_valid;
    logic [4:0]  req0_addr, req1_addr, rsv_addr;
    logic [63:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic [31:0] pending;

    int n_total;
    int n_pass;

    regfile_wb_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic        rv;
        logic [4:0]  ra;
        logic [1:0]  rdy;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [31:0] pend;
    } vec_t;

    vec_t tbl[13];

    // Reference model state: who wins the next tie, and the expected outputs
    int          m_favored;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;
    bit          m_pend[32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                                input logic rv, input logic [4:0] ra, input logic [1:0] rdy,
                                input logic we, input logic [4:0] wa, input logic [63:0] wd,
                                input logic [31:0] pend);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.rv = rv; v.ra = ra; v.rdy = rdy; v.we = we; v.wa = wa; v.wd = wd; v.pend = pend;
        return v;
    endfunction

    function automatic void model_reset();
        m_favored = 0;
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endfunction

    function automatic logic [31:0] model_pend_vec();
        logic [31:0] p;
        for (int i = 0; i < 32; i++) p[i] = m_pend[i];
        return p;
    endfunction

    // Advance the model one clock; returns winner (-1 none)
    function automatic int model_step(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                                      input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                                      input logic rv, input logic [4:0] ra);
        int w;
        int addr;
        w = -1;
        if (v0 && v1) w = m_favored;
        else if (v0)  w = 0;
        else if (v1)  w = 1;
        m_we = 1'b0;
        if (w >= 0) begin
            m_favored = 1 - w;
            addr = (w == 0) ? int'(a0) : int'(a1);
            if (addr != 31) begin
                m_we = 1'b1;
                m_wa = (w == 0) ? a0 : a1;
                m_wd = (w == 0) ? d0 : d1;
                m_pend[addr] = 1'b0;
            end
        end
        if (rv && ra != 5'd31) m_pend[ra] = 1'b1;
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; rsv_valid = 1'b0;
        req0_addr = '0; req1_addr = '0; rsv_addr = '0;
        req0_data = '0; req1_data = '0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One cycle: drive at negedge, sample ready before the edge, registered outputs after it
    task automatic apply(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                         input logic rv, input logic [4:0] ra,
                         output logic [1:0] rdy, output logic we, output logic [4:0] wa,
                         output logic [63:0] wd, output logic [31:0] pend);
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        rsv_valid = rv;  rsv_addr = ra;
        #1;
        rdy = {req1_ready, req0_ready};
        @(posedge clk);
        #1;
        we = we3; wa = wa3; wd = wd3; pend = pending;
    endtask

    logic [1:0]  r_rdy;
    logic        r_we;
    logic [4:0]  r_wa;
    logic [63:0] r_wd;
    logic [31:0] r_pend;

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsv_valid = 1'b0;
        req0_addr = '0; req1_addr = '0; rsv_addr = '0;
        req0_data = '0; req1_data = '0;
        model_reset();

        tbl[0]  = mk(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 2'b01, 1'b1, 5'd5, 64'hAA, 32'h0);
        tbl[1]  = mk(1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 2'b00, 1'b0, 5'd5, 64'hAA, 32'h0);
        tbl[2]  = mk(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 2'b10, 1'b1, 5'd2, 64'h22, 32'h0);
        tbl[3]  = mk(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 2'b01, 1'b1, 5'd1, 64'h11, 32'h0);
        tbl[4]  = mk(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 2'b10, 1'b1, 5'd2, 64'h22, 32'h0);
        tbl[5]  = mk(1'b0, 5'd0, 64'h0,  1'b1, 5'd31, 64'hFF, 1'b0, 5'd0, 2'b10, 1'b0, 5'd2, 64'h22, 32'h0);
        tbl[6]  = mk(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 2'b01, 1'b1, 5'd1, 64'h11, 32'h0);
        tbl[7]  = mk(1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 2'b00, 1'b0, 5'd1, 64'h11, 32'h80);
        tbl[8]  = mk(1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 2'b00, 1'b0, 5'd1, 64'h11, 32'h80);
        tbl[9]  = mk(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 2'b01, 1'b1, 5'd7, 64'h77, 32'h0);
        tbl[10] = mk(1'b0, 5'd0, 64'h0,  1'b1, 5'd9, 64'h99, 1'b1, 5'd9, 2'b10, 1'b1, 5'd9, 64'h99, 32'h200);
        tbl[11] = mk(1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 2'b00, 1'b0, 5'd9, 64'h99, 32'h200);
        tbl[12] = mk(1'b1, 5'd9, 64'h5,  1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 2'b01, 1'b1, 5'd9, 64'h5, 32'h0);

        do_reset();
        #1;
        chk("reset_we3", 64'(we3), 64'h0);
        chk("reset_wa3", 64'(wa3), 64'h0);
        chk("reset_wd3", wd3, 64'h0);
        chk("reset_pending", 64'(pending), 64'h0);
        chk("reset_ready_idle", 64'({req1_ready, req0_ready}), 64'h0);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1,
                  tbl[i].rv, tbl[i].ra, r_rdy, r_we, r_wa, r_wd, r_pend);
            chk($sformatf("tbl%0d_ready", i), 64'(r_rdy), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_we3", i), 64'(r_we), 64'(tbl[i].we));
            chk($sformatf("tbl%0d_wa3", i), 64'(r_wa), 64'(tbl[i].wa));
            chk($sformatf("tbl%0d_wd3", i), r_wd, tbl[i].wd);
            chk($sformatf("tbl%0d_pending", i), 64'(r_pend), 64'(tbl[i].pend));
        end

        // First tie after reset: grants 0,1,0,1 with back-to-back writes
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 5'd1, 64'h1111, 1'b1, 5'd2, 64'h2222, 1'b0, 5'd0,
                  r_rdy, r_we, r_wa, r_wd, r_pend);
            chk($sformatf("tie%0d_ready", i), 64'(r_rdy), (i % 2 == 0) ? 64'h1 : 64'h2);
            chk($sformatf("tie%0d_we3", i), 64'(r_we), 64'h1);
            chk($sformatf("tie%0d_wa3", i), 64'(r_wa), (i % 2 == 0) ? 64'd1 : 64'd2);
        end

        // Asynchronous reset right after a grant drops the write and reservations
        apply(1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'h0, 1'b1, 5'd4, r_rdy, r_we, r_wa, r_wd, r_pend);
        chk("prereset_we3", 64'(r_we), 64'h1);
        chk("prereset_pending", 64'(r_pend), 64'h10);
        req0_valid = 1'b0;
        rsv_valid  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_we3", 64'(we3), 64'h0);
        chk("async_reset_pending", 64'(pending), 64'h0);
        chk("async_reset_wa3", 64'(wa3), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Randomized traffic against the reference model; requesters hold until accepted
        begin
            logic        h0_v, h1_v;
            logic [4:0]  h0_a, h1_a, ra;
            logic [63:0] h0_d, h1_d;
            logic        rv;
            int          w;
            logic [1:0]  exp_rdy;
            h0_v = 1'b0; h1_v = 1'b0;
            h0_a = '0; h1_a = '0; h0_d = '0; h1_d = '0;
            for (int c = 0; c < 400; c++) begin
                if (!h0_v && $urandom_range(0, 9) < 6) begin
                    h0_v = 1'b1;
                    h0_a = 5'($urandom_range(0, 31));
                    h0_d = {$urandom, $urandom};
                end
                if (!h1_v && $urandom_range(0, 9) < 6) begin
                    h1_v = 1'b1;
                    h1_a = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                    h1_d = {$urandom, $urandom};
                end
                rv = 1'($urandom_range(0, 1));
                ra = 5'($urandom_range(0, 31));
                apply(h0_v, h0_a, h0_d, h1_v, h1_a, h1_d, rv, ra, r_rdy, r_we, r_wa, r_wd, r_pend);
                w = model_step(h0_v, h0_a, h0_d, h1_v, h1_a, h1_d, rv, ra);
                exp_rdy = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
                chk($sformatf("rnd%0d_ready", c), 64'(r_rdy), 64'(exp_rdy));
                chk($sformatf("rnd%0d_we3", c), 64'(r_we), 64'(m_we));
                chk($sformatf("rnd%0d_wa3", c), 64'(r_wa), 64'(m_wa));
                chk($sformatf("rnd%0d_wd3", c), r_wd, m_wd);
                chk($sformatf("rnd%0d_pending", c), 64'(r_pend), 64'(model_pend_vec()));
                if (w == 0) h0_v = 1'b0;
                if (w == 1) h1_v = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
